// File: rtl/rv32_sliced_alu_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_sliced_alu_fsm_if
// Description : Start/operand/result handshake bundle between the execute
//               controller (master) and the sliced multicycle ALU (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_sliced_alu_fsm_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic [2:0]      i_alu_sel;
  logic [XLEN-1:0] i_operand_one;
  logic [XLEN-1:0] i_operand_two;
  logic            i_result_ack;
  logic            o_busy;
  logic            o_data_valid;
  logic [XLEN-1:0] o_result;
  logic            o_carry_out;

  modport master (
    output i_start, i_alu_sel, i_operand_one, i_operand_two, i_result_ack,
    input  o_busy, o_data_valid, o_result, o_carry_out
  );

  modport slave (
    input  i_start, i_alu_sel, i_operand_one, i_operand_two, i_result_ack,
    output o_busy, o_data_valid, o_result, o_carry_out
  );
endinterface
`default_nettype wire

// File: rtl/rv32_sliced_alu_fsm.sv
`default_nettype none
// ============================================================================
// Module      : rv32_sliced_alu_fsm
// Description : Multicycle RV32 ALU that evaluates one XLEN-bit operation as
//               NUM_SLICES passes through a SLICE_W-bit datapath with ripple
//               carry between passes; result held until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_sliced_alu_fsm #(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  rv32_sliced_alu_fsm_if.slave  bus
);
  localparam int NUM_SLICES = XLEN / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;
  localparam logic [2:0] SEL_XOR  = 3'b100;
  localparam logic [2:0] SEL_SLT  = 3'b101;
  localparam logic [2:0] SEL_SLTU = 3'b110;
  localparam logic [2:0] SEL_RSV  = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // A partial slice would silently drop the top bits, so refuse to build.
  if ((XLEN % SLICE_W) != 0) begin : g_slice_check
    $error("SLICE_W must divide XLEN exactly");
  end

  logic [1:0]         state;
  logic [1:0]         next_state;
  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic [2:0]         sel_q;
  logic [IDX_W-1:0]   slice_idx;
  logic               carry_q;
  logic [XLEN-1:0]    result_q;
  logic               carry_out_q;
  logic               busy;
  logic               data_valid;

  logic               accept;
  logic               last_slice;
  logic               sub_in;
  logic               sub_q;
  int                 slice_base;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W:0]   slice_sum;
  logic [SLICE_W-1:0] slice_res;
  logic [XLEN-1:0]    merged;
  logic [XLEN-1:0]    final_result;
  logic               final_carry;

  // A start is taken from IDLE, or from HOLD in the same cycle as the ack.
  assign accept = bus.i_start && ((state == IDLE) || ((state == HOLD) && bus.i_result_ack));
  assign last_slice = (slice_idx == LAST_IDX);
  // Subtract-style operations run as A + ~B + 1 with the +1 seeded into carry_q.
  assign sub_in = (bus.i_alu_sel == SEL_SUB) || (bus.i_alu_sel == SEL_SLT) || (bus.i_alu_sel == SEL_SLTU);
  assign sub_q  = (sel_q == SEL_SUB) || (sel_q == SEL_SLT) || (sel_q == SEL_SLTU);
  assign slice_base = int'(slice_idx) * SLICE_W;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.i_start) next_state = RUN;
      RUN:     if (last_slice) next_state = HOLD;
      HOLD:    if (bus.i_result_ack) next_state = bus.i_start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy       = 1'b0;
    data_valid = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      HOLD:    begin busy = 1'b1; data_valid = 1'b1; end
      default: ;
    endcase
  end

  // One slice of the narrow datapath plus the final-result fix-ups.
  always_comb begin
    a_slice   = op_a[slice_base +: SLICE_W];
    b_slice   = op_b[slice_base +: SLICE_W];
    b_eff     = sub_q ? ~b_slice : b_slice;
    slice_sum = {1'b0, a_slice} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, carry_q};
    case (sel_q)
      SEL_AND: slice_res = a_slice & b_slice;
      SEL_OR:  slice_res = a_slice | b_slice;
      SEL_XOR: slice_res = a_slice ^ b_slice;
      SEL_RSV: slice_res = '0;
      default: slice_res = slice_sum[SLICE_W-1:0];
    endcase
    merged = result_q;
    merged[slice_base +: SLICE_W] = slice_res;
    final_result = merged;
    final_carry  = 1'b0;
    case (sel_q)
      SEL_ADD, SEL_SUB: final_carry = slice_sum[SLICE_W];
      // On the last slice the sum MSB is the sign of A-B; differing signs
      // override it so overflow cannot flip the comparison.
      SEL_SLT: final_result = {{(XLEN-1){1'b0}},
                               (op_a[XLEN-1] ^ op_b[XLEN-1]) ? op_a[XLEN-1] : slice_sum[SLICE_W-1]};
      SEL_SLTU: final_result = {{(XLEN-1){1'b0}}, ~slice_sum[SLICE_W]};
      SEL_RSV:  final_result = '0;
      default:  ;
    endcase
  end

  // Operand capture on accept, then one slice per RUN cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_a        <= '0;
      op_b        <= '0;
      sel_q       <= '0;
      slice_idx   <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      op_a      <= bus.i_operand_one;
      op_b      <= bus.i_operand_two;
      sel_q     <= bus.i_alu_sel;
      slice_idx <= '0;
      carry_q   <= sub_in;
    end else if (state == RUN) begin
      slice_idx <= slice_idx + IDX_W'(1);
      carry_q   <= slice_sum[SLICE_W];
      if (last_slice) begin
        result_q    <= final_result;
        carry_out_q <= final_carry;
      end else begin
        result_q    <= merged;
      end
    end
  end

  assign bus.o_busy       = busy;
  assign bus.o_data_valid = data_valid;
  assign bus.o_result     = result_q;
  assign bus.o_carry_out  = carry_out_q;
endmodule
`default_nettype wire

// File: tb/tb_rv32_sliced_alu_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_sliced_alu_fsm
// Description : Self-checking bench; drives 8-, 16- and 32-bit-slice builds
//               with shared stimulus and compares against a plain-arithmetic
//               reference model and a table of hand-derived vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_sliced_alu_fsm;
  localparam logic [2:0] S_ADD = 3'd0, S_SUB = 3'd1, S_AND = 3'd2, S_OR = 3'd3;
  localparam logic [2:0] S_XOR = 3'd4, S_SLT = 3'd5, S_SLTU = 3'd6, S_RSV = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ack;
  logic [2:0]  sel;
  logic [31:0] opa;
  logic [31:0] opb;

  logic        valid_v [3];
  logic        busy_v  [3];
  logic [31:0] res_v   [3];
  logic        cy_v    [3];
  int          lat_seen [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_cy;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  rv32_sliced_alu_fsm_if #(.XLEN(32)) bus8 ();
  rv32_sliced_alu_fsm_if #(.XLEN(32)) bus16 ();
  rv32_sliced_alu_fsm_if #(.XLEN(32)) bus32 ();

  rv32_sliced_alu_fsm #(.XLEN(32), .SLICE_W(8))  dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8));
  rv32_sliced_alu_fsm #(.XLEN(32), .SLICE_W(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(bus16));
  rv32_sliced_alu_fsm #(.XLEN(32), .SLICE_W(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32));

  assign bus8.i_start  = start;  assign bus16.i_start  = start;  assign bus32.i_start  = start;
  assign bus8.i_alu_sel = sel;   assign bus16.i_alu_sel = sel;   assign bus32.i_alu_sel = sel;
  assign bus8.i_operand_one = opa; assign bus16.i_operand_one = opa; assign bus32.i_operand_one = opa;
  assign bus8.i_operand_two = opb; assign bus16.i_operand_two = opb; assign bus32.i_operand_two = opb;
  assign bus8.i_result_ack = ack; assign bus16.i_result_ack = ack; assign bus32.i_result_ack = ack;

  assign valid_v[0] = bus8.o_data_valid;  assign valid_v[1] = bus16.o_data_valid;  assign valid_v[2] = bus32.o_data_valid;
  assign busy_v[0]  = bus8.o_busy;        assign busy_v[1]  = bus16.o_busy;        assign busy_v[2]  = bus32.o_busy;
  assign res_v[0]   = bus8.o_result;      assign res_v[1]   = bus16.o_result;      assign res_v[2]   = bus32.o_result;
  assign cy_v[0]    = bus8.o_carry_out;   assign cy_v[1]    = bus16.o_carry_out;   assign cy_v[2]    = bus32.o_carry_out;

  // Start-to-valid latency of each build: 32 / SLICE_W.
  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  // Reference: {carry, result} straight from the operation definitions.
  function automatic logic [32:0] model(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] m;
    case (s)
      S_ADD:   m = {1'b0, a} + {1'b0, b};
      S_SUB:   m = {1'b0, a} + {1'b0, ~b} + 33'd1;
      S_AND:   m = {1'b0, a & b};
      S_OR:    m = {1'b0, a | b};
      S_XOR:   m = {1'b0, a ^ b};
      S_SLT:   m = ($signed(a) < $signed(b)) ? 33'd1 : 33'd0;
      S_SLTU:  m = (a < b) ? 33'd1 : 33'd0;
      default: m = 33'd0;
    endcase
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; sel = s; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) until every build shows valid, recording each latency.
  task automatic wait_all();
    int cnt = 0;
    int seen;
    for (int k = 0; k < 3; k++) lat_seen[k] = -1;
    while (cnt < 40) begin
      seen = 0;
      for (int k = 0; k < 3; k++) begin
        if (lat_seen[k] < 0 && valid_v[k]) lat_seen[k] = cnt;
        if (lat_seen[k] >= 0) seen++;
      end
      if (seen == 3) break;
      @(posedge clk); #1;
      cnt++;
    end
    for (int k = 0; k < 3; k++) chk($sformatf("valid_reached_dut%0d", k), 32'(valid_v[k]), 32'd1);
  endtask

  task automatic ack_op();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_busy%0d", tag, k),  32'(busy_v[k]),  32'd0);
      chk($sformatf("%s_valid%0d", tag, k), 32'(valid_v[k]), 32'd0);
      chk($sformatf("%s_res%0d", tag, k),   res_v[k],        32'd0);
      chk($sformatf("%s_cy%0d", tag, k),    32'(cy_v[k]),    32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [32:0] m;
    int spurious;
    tbl[0]  = '{S_ADD,  32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0};
    tbl[1]  = '{S_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    tbl[2]  = '{S_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    tbl[3]  = '{S_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
    tbl[4]  = '{S_SUB,  32'h00000007, 32'h00000005, 32'h00000002, 1'b1};
    tbl[5]  = '{S_SUB,  32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
    tbl[6]  = '{S_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    tbl[7]  = '{S_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    tbl[8]  = '{S_SLTU, 32'h00000003, 32'h00000009, 32'h00000001, 1'b0};
    tbl[9]  = '{S_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
    tbl[10] = '{S_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    tbl[11] = '{S_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    tbl[12] = '{S_OR,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0};
    tbl[13] = '{S_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0};
    tbl[14] = '{S_RSV,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0};

    rst = 1'b1; start = 1'b0; ack = 1'b0; sel = 3'd0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on all three builds.
    for (int i = 0; i < 15; i++) begin
      start_op(tbl[i].sel, tbl[i].a, tbl[i].b);
      for (int k = 0; k < 3; k++) chk($sformatf("v%0d_busy%0d", i, k), 32'(busy_v[k]), 32'd1);
      wait_all();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("v%0d_res%0d", i, k), res_v[k], tbl[i].exp_res);
        chk($sformatf("v%0d_cy%0d", i, k), 32'(cy_v[k]), 32'(tbl[i].exp_cy));
        chk($sformatf("v%0d_lat%0d", i, k), 32'(lat_seen[k]), 32'(lat_of(k)));
      end
      ack_op();
    end

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  rs;
      logic [31:0] ra;
      logic [31:0] rb;
      rs = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 7 == 3) ? ra : $urandom;
      m  = model(rs, ra, rb);
      start_op(rs, ra, rb);
      wait_all();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rnd%0d_res%0d", i, k), res_v[k], m[31:0]);
        chk($sformatf("rnd%0d_cy%0d", i, k), 32'(cy_v[k]), 32'(m[32]));
      end
      ack_op();
    end

    // Result and status must hold while ack stays low.
    start_op(S_ADD, 32'h12345678, 32'h11111111);
    wait_all();
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_res", res_v[0], 32'h23456789);
      chk("hold_cy", 32'(cy_v[0]), 32'd0);
      chk("hold_busy", 32'(busy_v[0]), 32'd1);
      chk("hold_valid", 32'(valid_v[0]), 32'd1);
    end
    ack_op();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("after_ack_valid%0d", k), 32'(valid_v[k]), 32'd0);
      chk($sformatf("after_ack_busy%0d", k), 32'(busy_v[k]), 32'd0);
    end

    // Start pulse and operand changes during RUN must not disturb the op.
    start_op(S_SUB, 32'd100, 32'd30);
    @(negedge clk);
    start = 1'b1; sel = S_ADD; opa = 32'hDEADBEEF; opb = 32'h01010101;
    @(posedge clk); #1;
    start = 1'b0; opa = 32'h0; opb = 32'hFFFFFFFF;
    wait_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ignore_res%0d", k), res_v[k], 32'd70);
      chk($sformatf("ignore_cy%0d", k), 32'(cy_v[k]), 32'd1);
    end
    ack_op();
    spurious = 0;
    repeat (6) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) if (valid_v[k] || busy_v[k]) spurious++;
    end
    chk("no_second_op", 32'(spurious), 32'd0);

    // Back-to-back: ack of AND together with start of OR.
    start_op(S_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    wait_all();
    for (int k = 0; k < 3; k++) chk($sformatf("b2b_first%0d", k), res_v[k], 32'hF000F000);
    @(negedge clk);
    ack = 1'b1; start = 1'b1; sel = S_OR; opa = 32'h0F0F0000; opb = 32'h000000FF;
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b_valid_low%0d", k), 32'(valid_v[k]), 32'd0);
      chk($sformatf("b2b_busy%0d", k), 32'(busy_v[k]), 32'd1);
    end
    wait_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b_second%0d", k), res_v[k], 32'h0F0F00FF);
      chk($sformatf("b2b_lat%0d", k), 32'(lat_seen[k]), 32'(lat_of(k)));
    end
    ack_op();

    // Reset while the 8-bit build is on slice 2.
    start_op(S_ADD, 32'h00000001, 32'h00000002);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    start_op(S_XOR, 32'hAAAAAAAA, 32'hFFFFFFFF);
    wait_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_rst_res%0d", k), res_v[k], 32'h55555555);
      chk($sformatf("post_rst_lat%0d", k), 32'(lat_seen[k]), 32'(lat_of(k)));
    end
    ack_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
